// File: rtl/memcpy_arbiter_if.sv
// Request/engine signal bundle between the requesters, the arbiter and the copy engine.
interface memcpy_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][63:0] req_src;
  logic [NUM_REQ-1:0][63:0] req_dst;
  logic [NUM_REQ-1:0][14:0] req_size;
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ-1:0]       req_done;
  logic                     req_err;
  logic                     busy;
  logic                     mc_en;
  logic [63:0]              mc_src;
  logic [63:0]              mc_dst;
  logic [14:0]              mc_size;
  logic                     mc_done;

  modport master (
    output req, req_src, req_dst, req_size, mc_done,
    input  req_ack, req_done, req_err, busy, mc_en, mc_src, mc_dst, mc_size
  );

  modport slave (
    input  req, req_src, req_dst, req_size, mc_done,
    output req_ack, req_done, req_err, busy, mc_en, mc_src, mc_dst, mc_size
  );
endinterface

// File: rtl/memcpy_arbiter.sv
// Round-robin arbiter granting NUM_REQ memcpy requesters access to one copy engine,
// with a BUSY watchdog that aborts transfers the engine never completes.
module memcpy_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  memcpy_arbiter_if.slave bus
);
  localparam int unsigned       IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned       WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);
  localparam logic [WW-1:0]      WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_COMPLETE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      w_win_idx;
  logic               w_win_vld;
  int unsigned        w_idx;
  logic [63:0]        r_src;
  logic [63:0]        r_dst;
  logic [14:0]        r_size;
  logic               r_err;
  logic               w_err_nxt;
  logic [WW-1:0]      r_wdog;
  logic [WW-1:0]      w_wdog_inc;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_done;
  logic               r_req_err;
  logic               r_busy;
  logic               r_mc_en;
  logic [63:0]        r_mc_src;
  logic [63:0]        r_mc_dst;
  logic [14:0]        r_mc_size;

  // Search starts one past the last grant and wraps; first set bit wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = 32'(r_last) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_win_vld && bus.req[IW'(w_idx)]) begin
        w_win_vld = 1'b1;
        w_win_idx = IW'(w_idx);
      end
    end
  end

  assign w_wdog_inc = r_wdog + WW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = (bus.req_size[w_win_idx] == '0) ? S_COMPLETE : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_BUSY;
      S_BUSY: begin
        // Engine completion takes priority over a watchdog expiry in the same cycle.
        if (bus.mc_done) begin
          w_state_nxt = S_COMPLETE;
          w_err_nxt   = 1'b0;
        end else if (w_wdog_inc == WD_LAST) begin
          w_state_nxt = S_COMPLETE;
          w_err_nxt   = 1'b1;
        end
      end
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last    <= IW'(NUM_REQ - 1);
      r_owner   <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_size    <= '0;
      r_err     <= 1'b0;
      r_wdog    <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_req_err <= 1'b0;
      r_busy    <= 1'b0;
      r_mc_en   <= 1'b0;
      r_mc_src  <= '0;
      r_mc_dst  <= '0;
      r_mc_size <= '0;
    end else begin
      r_ack     <= '0;
      r_done    <= '0;
      r_req_err <= 1'b0;
      r_mc_en   <= 1'b0;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_err     <= w_err_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_owner <= w_win_idx;
            r_src   <= bus.req_src[w_win_idx];
            r_dst   <= bus.req_dst[w_win_idx];
            r_size  <= bus.req_size[w_win_idx];
            r_ack   <= ONE << w_win_idx;
          end
        end
        S_ISSUE: begin
          r_mc_en   <= 1'b1;
          r_mc_src  <= r_src;
          r_mc_dst  <= r_dst;
          r_mc_size <= r_size;
          r_wdog    <= '0;
        end
        S_BUSY: r_wdog <= w_wdog_inc;
        S_COMPLETE: begin
          r_done    <= ONE << r_owner;
          r_req_err <= r_err;
          r_last    <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack  = r_ack;
  assign bus.req_done = r_done;
  assign bus.req_err  = r_req_err;
  assign bus.busy     = r_busy;
  assign bus.mc_en    = r_mc_en;
  assign bus.mc_src   = r_mc_src;
  assign bus.mc_dst   = r_mc_dst;
  assign bus.mc_size  = r_mc_size;
endmodule

// File: tb/tb_memcpy_arbiter.sv
// Bench for memcpy_arbiter: directed scenarios plus randomized transfers checked against
// a round-robin/timing reference model.
module tb_memcpy_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned TO  = 16;
  localparam int unsigned IWT = $clog2(NR);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memcpy_arbiter_if #(.NUM_REQ(NR)) bus ();
  memcpy_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks   = 0;
  int n_errs     = 0;
  int model_last = NR - 1;
  logic [63:0] src_a  [NR];
  logic [63:0] dst_a  [NR];
  logic [14:0] size_a [NR];
  logic [63:0] mdl_mc_src  = '0;
  logic [63:0] mdl_mc_dst  = '0;
  logic [14:0] mdl_mc_size = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int off = 1; off <= int'(NR); off++) begin
      int idx;
      idx = (last + off) % int'(NR);
      if (r[IWT'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_ops(input int i);
    bus.req_src[IWT'(i)]  = src_a[i];
    bus.req_dst[IWT'(i)]  = dst_a[i];
    bus.req_size[IWT'(i)] = size_a[i];
  endtask

  task automatic set_ops(input int i, input logic [63:0] s, input logic [63:0] d, input logic [14:0] z);
    src_a[i] = s; dst_a[i] = d; size_a[i] = z;
    drive_ops(i);
  endtask

  task automatic rand_ops(input int i);
    src_a[i]  = {$urandom, $urandom};
    dst_a[i]  = {$urandom, $urandom};
    size_a[i] = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(1, 32767));
    drive_ops(i);
  endtask

  // Entered in a cycle where the arbiter is idle and the wanted requests are already driven.
  // done_dly: cycle (relative to the mc_en cycle) in which mc_done pulses; -1 = never.
  task automatic serve(input string tag, input int owner, input int done_dly, input bit drop);
    logic [63:0] es, ed;
    logic [14:0] esz;
    bit          eerr;
    int          edone, t, seen_done, extra_en, stray_ack;
    es   = src_a[owner];
    ed   = dst_a[owner];
    esz  = size_a[owner];
    eerr = (esz != 0) && (done_dly < 0 || done_dly > int'(TO) - 2);
    tick();
    chk({tag, ".ack"},       64'(bus.req_ack), 64'(oh(owner)));
    chk({tag, ".busy_ack"},  64'(bus.busy),    64'd1);
    chk({tag, ".en_at_ack"}, 64'(bus.mc_en),   64'd0);
    if (drop) bus.req[IWT'(owner)] = 1'b0;
    rand_ops(owner);
    if (esz != 0) begin
      tick();
      chk({tag, ".mc_en"},   64'(bus.mc_en),   64'd1);
      chk({tag, ".mc_src"},  bus.mc_src,       es);
      chk({tag, ".mc_dst"},  bus.mc_dst,       ed);
      chk({tag, ".mc_size"}, 64'(bus.mc_size), 64'(esz));
      mdl_mc_src = es; mdl_mc_dst = ed; mdl_mc_size = esz;
      edone     = eerr ? int'(TO) : done_dly + 2;
      seen_done = -1;
      extra_en  = 0;
      stray_ack = 0;
      t         = 0;
      while (t < 40 && seen_done < 0) begin
        bus.mc_done = (t == done_dly);
        tick();
        t++;
        bus.mc_done = 1'b0;
        if (bus.req_done != '0) seen_done = t;
        else begin
          if (bus.mc_en) extra_en++;
          if (bus.req_ack != '0) stray_ack++;
        end
      end
      chk({tag, ".done_cyc"},  64'(seen_done), 64'(edone));
      chk({tag, ".extra_en"},  64'(extra_en),  64'd0);
      chk({tag, ".stray_ack"}, 64'(stray_ack), 64'd0);
    end else begin
      tick();
    end
    chk({tag, ".done"},      64'(bus.req_done), 64'(oh(owner)));
    chk({tag, ".err"},       64'(bus.req_err),  64'(eerr));
    chk({tag, ".ack_gap"},   64'(bus.req_ack),  64'd0);
    chk({tag, ".en_done"},   64'(bus.mc_en),    64'd0);
    chk({tag, ".src_hold"},  bus.mc_src,        mdl_mc_src);
    chk({tag, ".size_hold"}, 64'(bus.mc_size),  64'(mdl_mc_size));
    chk({tag, ".idle"},      64'(bus.busy),     64'd0);
    model_last = owner;
  endtask

  initial begin
    int fair_order [5];
    int cnt;
    logic [NR-1:0] r;
    int owner, dly;
    fair_order = '{0, 1, 2, 3, 0};

    reset       = 1'b0;
    bus.mc_done = 1'b0;
    for (int i = 0; i < int'(NR); i++)
      set_ops(i, 64'h100 * (i + 1), 64'h8000 + 64'h100 * i, 15'd16);
    bus.req = '1;
    repeat (3) tick();
    chk("rst.ack",  64'(bus.req_ack),  64'd0);
    chk("rst.done", 64'(bus.req_done), 64'd0);
    chk("rst.err",  64'(bus.req_err),  64'd0);
    chk("rst.busy", 64'(bus.busy),     64'd0);
    chk("rst.en",   64'(bus.mc_en),    64'd0);
    chk("rst.src",  bus.mc_src,        64'd0);
    chk("rst.dst",  bus.mc_dst,        64'd0);
    chk("rst.size", 64'(bus.mc_size),  64'd0);
    reset = 1'b1;
    #2;
    chk("rel.ack_before_edge",  64'(bus.req_ack), 64'd0);
    chk("rel.busy_before_edge", 64'(bus.busy),    64'd0);

    for (int k = 0; k < 5; k++) serve("fair", fair_order[k], 3, 1'b0);
    bus.req = '0;

    set_ops(0, 64'h1000, 64'h2000, 15'd64);
    bus.req = 4'b0001;
    serve("single", 0, 10, 1'b1);

    set_ops(2, 64'h3333, 64'h4444, 15'd0);
    bus.req = 4'b0100;
    serve("zero", 2, 3, 1'b1);

    set_ops(1, 64'hAAAA_0000_1111, 64'hBBBB_0000_2222, 15'd200);
    bus.req = 4'b0010;
    serve("opchg", 1, 4, 1'b1);

    set_ops(1, 64'h5000, 64'h6000, 15'd32);
    set_ops(3, 64'h7000, 64'h9000, 15'd48);
    bus.req = 4'b1010;
    serve("tmo", 3, -1, 1'b1);
    set_ops(1, 64'h5000, 64'h6000, 15'd32);
    serve("tmo_next", 1, 5, 1'b1);

    set_ops(0, 64'hC000, 64'hD000, 15'd8);
    bus.req = 4'b0001;
    serve("race", 0, int'(TO) - 2, 1'b1);
    set_ops(2, 64'hE000, 64'hF000, 15'd8);
    bus.req = 4'b0100;
    serve("late", 2, int'(TO) - 1, 1'b1);

    for (int it = 0; it < 24; it++) begin
      r = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < int'(NR); i++) rand_ops(i);
      bus.req = r;
      owner = rr_pick(r, model_last);
      dly   = $urandom_range(0, 16);
      if (dly == 16) dly = -1;
      serve("rnd", owner, dly, 1'b0);
      bus.req = '0;
    end

    set_ops(3, 64'h1234, 64'h5678, 15'd100);
    bus.req = 4'b1000;
    tick();
    chk("mid.ack", 64'(bus.req_ack), 64'(oh(3)));
    bus.req = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("mid.ack0",  64'(bus.req_ack),  64'd0);
    chk("mid.done0", 64'(bus.req_done), 64'd0);
    chk("mid.err0",  64'(bus.req_err),  64'd0);
    chk("mid.busy0", 64'(bus.busy),     64'd0);
    chk("mid.en0",   64'(bus.mc_en),    64'd0);
    chk("mid.src0",  bus.mc_src,        64'd0);
    chk("mid.dst0",  bus.mc_dst,        64'd0);
    chk("mid.size0", 64'(bus.mc_size),  64'd0);
    repeat (2) tick();
    reset       = 1'b1;
    bus.mc_done = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.req_done != '0 || bus.busy) cnt++;
      tick();
    end
    chk("mid.no_done", 64'(cnt), 64'd0);
    model_last  = NR - 1;
    mdl_mc_src  = '0;
    mdl_mc_dst  = '0;
    mdl_mc_size = '0;
    for (int i = 0; i < int'(NR); i++) set_ops(i, 64'h40 * (i + 1), 64'h900 + i, 15'd24);
    bus.req = '1;
    serve("rst_next", 0, 2, 1'b0);
    bus.req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
